dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache for the memory stage, with its miss-handling FSM.
- Produces CacheStall, which the hazard logic consumes to freeze Fetch/Decode/Execute/Memory and flush Writeback.
- Services the CPU load/store combinationally on a hit.
- On a miss, writes back a dirty victim line, then refills the line word-by-word over a req/ack main-memory port.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte enables).
- NUM_SETS, 256, number of lines; power of two, ≥2.
- WORDS_PER_LINE, 4, words per line; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemReadM  in  1  load request from the memory stage.
- MemWriteM  in  1  store request from the memory stage.
- AddrM  in  ADDR_WIDTH  byte address; bits [1:0] ignored (word aligned).
- WriteDataM  in  32  store data.
- ByteEnM  in  4  store byte enables.
- ReadDataM  out  32  load data; valid in the cycle CacheStall=0 with MemReadM=1.
- CacheStall  out  1  combinational; high while the request cannot complete this cycle.
- mem_req  out  1  main-memory word transfer request.
- mem_we  out  1  1 = write (writeback), 0 = read (refill).
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  32  writeback data.
- mem_rdata  in  32  refill data; valid with mem_ack.
- mem_ack  in  1  completes one word transfer in the cycle it is sampled high with mem_req=1.

Behaviour:
- Address split: [1:0] byte offset; next log2(WORDS_PER_LINE) bits word offset; next log2(NUM_SETS) bits index; remaining bits tag.
- Per-line state: valid, dirty, tag, data.
  - Only the valid bits are reset.
  - Data, tag and dirty arrays are not reset.
- Requester contract: AddrM, MemReadM, MemWriteM, WriteDataM and ByteEnM are held stable while CacheStall=1.
- MemWriteM=1 takes priority if both MemWriteM and MemReadM are asserted.
- FSM states: IDLE, WRITEBACK, REFILL, UPDATE.
- IDLE, no request: CacheStall=0; mem_req=0.
- IDLE hit (valid & tag match):
  - CacheStall=0.
  - Load: ReadDataM = line word, combinationally.
  - Store: bytes selected by ByteEnM are written at the clock edge; dirty is set.
- IDLE miss:
  - CacheStall=1 in the same cycle.
  - Next state is WRITEBACK if the victim is valid & dirty, otherwise REFILL.
  - Word counter is cleared to 0.
- WRITEBACK:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim tag, index, counter, 2'b00}; mem_wdata = victim word[counter].
  - On mem_ack: counter increments.
  - On the last word: counter clears to 0 and next state is REFILL.
- REFILL:
  - mem_req=1, mem_we=0.
  - mem_addr = {request tag, index, counter, 2'b00}.
  - On mem_ack: mem_rdata is written into word[counter]; counter increments.
  - On the last word: next state is UPDATE.
- UPDATE: tag ← request tag, valid ← 1, dirty ← 0; next state IDLE.
- The next IDLE cycle re-evaluates the held request as a hit.
  - CacheStall falls that cycle; a store completes that cycle.
- CacheStall = 1 in WRITEBACK, REFILL and UPDATE, and for an IDLE miss.
- Without mem_ack, mem_req/mem_addr hold indefinitely; there is no timeout.
- Word transfers are back-to-back: the next word's req/addr are presented in the cycle after an ack.
- Miss latency with single-cycle ack, clean victim: miss detected in cycle 0; REFILL occupies cycles 1..W; UPDATE in cycle W+1; hit with CacheStall=0 in cycle W+2.
  - Dirty victim: add W cycles.
- Reset values: state=IDLE, counter=0, all valid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - CacheStall=0 and ReadDataM=0 with no request pending.
- Reset asserted mid-transfer: the transfer is aborted and mem_req drops immediately (asynchronously).
  - The partially refilled line stays invalid.
- mem_ack while mem_req=0: ignored.

Test Plan:
- Cold load at AddrM=0x0000_1000, W=4, ack every cycle -> CacheStall=1 in the request cycle; 4 reads at addresses 0x1000, 0x1004, 0x1008, 0x100C; CacheStall=0 six cycles later (cycle W+2); ReadDataM = word returned for 0x1000.
- After the refill, load 0x1008 -> no stall; ReadDataM = third refill word.
- Store 0xDEADBEEF, ByteEnM=4'b0011 to cached 0x1004 -> no stall; a later load returns the upper half unchanged and lower half 0xBEEF.
- Load 0x2004 (same index, different tag) while the line is dirty -> 4 writes to 0x1000..0x100C with the updated 0x1004 data, then 4 reads 0x2000..0x200C, then a hit.
- mem_ack delayed 3 cycles per word -> mem_req/mem_addr stable throughout; CacheStall held until completion.
- rst_n low during the second refill word -> mem_req=0 immediately; after release, the same load misses again and refills from word 0.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with a miss FSM that writes back
// a dirty victim, then refills the line one word at a time over a req/ack memory port.
module dcache_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SETS       = 256,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [ADDR_WIDTH-1:0] AddrM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic [3:0]            ByteEnM,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  CacheStall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
);

   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] WORD0 = '0;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;

   state_t                state;
   logic [OFF_W-1:0]      cnt;
   logic [OFF_W-1:0]      cnt_nxt;
   logic [NUM_SETS-1:0]   valid;
   logic [NUM_SETS-1:0]   dirty;
   logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
   logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][WORDS_PER_LINE];

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] word;
   logic             req, hit, idle, store_hit, xfer, last;
   logic             unused_ok;

   assign word    = AddrM[2 +: OFF_W];
   assign idx     = AddrM[2+OFF_W +: IDX_W];
   assign req_tag = AddrM[ADDR_WIDTH-1 -: TAG_W];
   assign unused_ok = &{1'b0, AddrM[1:0]};

   assign req       = MemReadM | MemWriteM;
   assign hit       = valid[idx] && (tag_mem[idx] == req_tag);
   assign idle      = (state == IDLE);
   assign store_hit = idle && MemWriteM && hit;
   assign xfer      = mem_req && mem_ack;
   assign last      = (cnt == LAST_WORD);
   assign cnt_nxt   = cnt + OFF_W'(1);

   assign CacheStall = !idle || (req && !hit);
   assign ReadDataM  = (idle && MemReadM && hit) ? data_mem[idx][word] : '0;

   // Control state; the line is invalidated at miss entry so an aborted refill never looks valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         valid     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: if (req && !hit) begin
               cnt        <= '0;
               valid[idx] <= 1'b0;
               mem_req    <= 1'b1;
               if (valid[idx] && dirty[idx]) begin
                  state     <= WRITEBACK;
                  mem_we    <= 1'b1;
                  mem_addr  <= {tag_mem[idx], idx, WORD0, 2'b00};
                  mem_wdata <= data_mem[idx][WORD0];
               end else begin
                  state    <= REFILL;
                  mem_we   <= 1'b0;
                  mem_addr <= {req_tag, idx, WORD0, 2'b00};
               end
            end
            WRITEBACK: if (xfer) begin
               cnt <= cnt_nxt;
               if (last) begin
                  state    <= REFILL;
                  mem_we   <= 1'b0;
                  mem_addr <= {req_tag, idx, WORD0, 2'b00};
               end else begin
                  mem_addr  <= {tag_mem[idx], idx, cnt_nxt, 2'b00};
                  mem_wdata <= data_mem[idx][cnt_nxt];
               end
            end
            REFILL: if (xfer) begin
               cnt <= cnt_nxt;
               if (last) begin
                  state   <= UPDATE;
                  mem_req <= 1'b0;
               end else begin
                  mem_addr <= {req_tag, idx, cnt_nxt, 2'b00};
               end
            end
            UPDATE: begin
               valid[idx] <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: data, tag and dirty arrays have no reset; only valid gates their use, and
   // leaving them out of reset lets them map onto plain RAM.
   always_ff @(posedge clk) begin
      if (store_hit) begin
         for (int b = 0; b < 4; b++)
            if (ByteEnM[b]) data_mem[idx][word][8*b +: 8] <= WriteDataM[8*b +: 8];
         dirty[idx] <= 1'b1;
      end
      if (state == REFILL && xfer) data_mem[idx][cnt] <= mem_rdata;
      if (state == UPDATE) begin
         tag_mem[idx] <= req_tag;
         dirty[idx]   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a word-addressed memory model with programmable ack
// delay answers the miss port; hits are checked from a vector table.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemReadM = 1'b0, MemWriteM = 1'b0;
   logic [31:0] AddrM = '0, WriteDataM = '0;
   logic [3:0]  ByteEnM = '0;
   logic [31:0] ReadDataM;
   logic        CacheStall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   dcache_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AddrM(AddrM),
      .WriteDataM(WriteDataM), .ByteEnM(ByteEnM), .ReadDataM(ReadDataM),
      .CacheStall(CacheStall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else passed++;
   endtask

   // Memory model: unwritten words read back as 0x1000_0000 | address.
   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} xfer_t;
   xfer_t       log_q[$];
   logic [31:0] mem_model [logic [31:0]];
   int          ack_delay = 0;
   bit          ack_force = 1'b0;
   int          wait_cnt  = 0;
   int          unstable  = 0;
   bit          waiting   = 1'b0;
   logic [31:0] hold_addr = '0;

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return mem_model.exists(a) ? mem_model[a] : (32'h1000_0000 | a);
   endfunction

   always @(negedge clk) begin
      if (mem_req) begin
         if (waiting && mem_addr !== hold_addr) unstable++;
         if (wait_cnt < ack_delay) begin
            mem_ack = 1'b0; wait_cnt++; waiting = 1'b1; hold_addr = mem_addr;
         end else begin
            mem_ack = 1'b1; wait_cnt = 0; waiting = 1'b0;
            if (mem_we) begin
               mem_model[mem_addr] = mem_wdata;
               log_q.push_back({1'b1, mem_addr, mem_wdata});
            end else begin
               mem_rdata = rd_model(mem_addr);
               log_q.push_back({1'b0, mem_addr, mem_rdata});
            end
         end
      end else begin
         if (waiting) unstable++;
         waiting = 1'b0; wait_cnt = 0; mem_ack = ack_force;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Counts cycles from the request cycle (cycle 0) to the first cycle with CacheStall=0.
   task automatic run_miss(output int n);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (CacheStall && n < 80);
   endtask

   function automatic logic [64:0] log_at(input int k);
      return (k < log_q.size()) ? log_q[k] : '1;
   endfunction

   typedef struct {
      logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
      logic exp_stall; logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs[8];

   logic [31:0] wb_exp[4];
   int n;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_1008, 32'h0,         4'h0, 1'b0, 32'h1000_1008};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_100C, 32'h0,         4'h0, 1'b0, 32'h1000_100C};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h3, 1'b0, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,         4'h0, 1'b0, 32'h1000_BEEF};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_1003, 32'h0,         4'h0, 1'b0, 32'h1000_1000};
      vecs[6] = '{1'b0, 1'b1, 32'h0000_100C, 32'h1122_3344, 4'h8, 1'b0, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_100C, 32'h0,         4'h0, 1'b0, 32'h1100_100C};
      wb_exp = '{32'h1000_1000, 32'h1000_BEEF, 32'h1000_1008, 32'h1100_100C};

      // Reset state
      repeat (2) @(posedge clk); #1;
      check("rst_mem_req", 65'(mem_req), 65'(0));
      check("rst_stall", 65'(CacheStall), 65'(0));
      check("rst_rdata", 65'(ReadDataM), 65'(0));
      @(negedge clk); rst_n = 1'b1; #1;
      check("rst_mem_we", 65'(mem_we), 65'(0));
      check("rst_mem_addr", 65'(mem_addr), 65'(0));
      check("rst_mem_wdata", 65'(mem_wdata), 65'(0));

      // Cold load, clean victim, ack every cycle
      @(negedge clk); log_q.delete(); MemReadM = 1'b1; AddrM = 32'h0000_1000; #1;
      check("cold_stall_req_cycle", 65'(CacheStall), 65'(1));
      run_miss(n);
      check("cold_latency", 65'(n), 65'(6));
      check("cold_rdata", 65'(ReadDataM), 65'(32'h1000_1000));
      check("cold_log_len", 65'(log_q.size()), 65'(4));
      for (int i = 0; i < 4; i++)
         check($sformatf("cold_xfer%0d", i), log_at(i),
               {1'b0, 32'h1000 + 32'(4*i), 32'h1000_1000 + 32'(4*i)});

      // Hit vectors on the refilled line
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         MemReadM = vecs[i].rd; MemWriteM = vecs[i].wr; AddrM = vecs[i].addr;
         WriteDataM = vecs[i].wdata; ByteEnM = vecs[i].be;
         #1;
         check($sformatf("vec%0d_stall", i), 65'(CacheStall), 65'(vecs[i].exp_stall));
         check($sformatf("vec%0d_rdata", i), 65'(ReadDataM), 65'(vecs[i].exp_rdata));
      end
      @(negedge clk); MemReadM = 1'b0; MemWriteM = 1'b0; ByteEnM = '0;

      // Conflict miss on a dirty line: writeback then refill
      @(negedge clk); log_q.delete(); MemReadM = 1'b1; AddrM = 32'h0000_2004; #1;
      check("evict_stall_req_cycle", 65'(CacheStall), 65'(1));
      run_miss(n);
      check("evict_latency", 65'(n), 65'(10));
      check("evict_rdata", 65'(ReadDataM), 65'(32'h1000_2004));
      check("evict_log_len", 65'(log_q.size()), 65'(8));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("evict_wb%0d", i), log_at(i), {1'b1, 32'h1000 + 32'(4*i), wb_exp[i]});
         check($sformatf("evict_rf%0d", i), log_at(4 + i),
               {1'b0, 32'h2000 + 32'(4*i), 32'h1000_2000 + 32'(4*i)});
      end
      @(negedge clk); MemReadM = 1'b0;

      // Slow memory: 3 wait cycles per word
      @(negedge clk); log_q.delete(); ack_delay = 3; unstable = 0;
      MemReadM = 1'b1; AddrM = 32'h0000_3000;
      run_miss(n);
      check("slow_latency", 65'(n), 65'(18));
      check("slow_req_addr_stable", 65'(unstable), 65'(0));
      check("slow_rdata", 65'(ReadDataM), 65'(32'h1000_3000));
      check("slow_log_last", log_at(3), {1'b0, 32'h0000_300C, 32'h1000_300C});
      @(negedge clk); MemReadM = 1'b0; ack_delay = 0;

      // Reset during the second refill word
      @(negedge clk); log_q.delete(); MemReadM = 1'b1; AddrM = 32'h0000_4000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_addr_word1", 65'(mem_addr), 65'(32'h0000_4004));
      check("abort_req_before", 65'(mem_req), 65'(1));
      rst_n = 1'b0; #1;
      check("abort_req_dropped", 65'(mem_req), 65'(0));
      @(negedge clk); rst_n = 1'b1; log_q.delete();
      run_miss(n);
      check("abort_remiss_latency", 65'(n), 65'(6));
      check("abort_remiss_word0", log_at(0), {1'b0, 32'h0000_4000, 32'h1000_4000});
      check("abort_remiss_rdata", 65'(ReadDataM), 65'(32'h1000_4000));
      @(negedge clk); MemReadM = 1'b0;

      // Stray ack with no request pending is ignored
      @(negedge clk); ack_force = 1'b1;
      @(posedge clk); #1;
      check("stray_ack_req", 65'(mem_req), 65'(0));
      check("stray_ack_stall", 65'(CacheStall), 65'(0));
      @(negedge clk); ack_force = 1'b0; MemReadM = 1'b1; AddrM = 32'h0000_4008; #1;
      check("stray_ack_hit_stall", 65'(CacheStall), 65'(0));
      check("stray_ack_hit_rdata", 65'(ReadDataM), 65'(32'h1000_4008));
      @(negedge clk); MemReadM = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
